// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Optional feature macro: ADDSUB_ZERO_FLAG_EN (adds rsp_zero to the interface).
package nibble_serial_addsub_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index; never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/response channel bundle for the nibble-serial add/subtract sequencer.
// With ADDSUB_ZERO_FLAG_EN defined the response also carries rsp_zero.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  import nibble_serial_addsub_ctrl_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_ovf;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic         rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf
  );
`endif

endinterface

// File: rtl/nibble_serial_addsub_ctrl_nibble_add_cin.sv
// Combinational 4-bit adder with carry-in; also exposes the carry into bit 3
// so the caller can derive signed overflow on the most significant nibble.
module nibble_add_cin
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [3:0] lo_sum;
  logic [1:0] hi_sum;

  // Split at bit 3 so the carry into the top bit is an explicit net.
  assign lo_sum = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
  assign c3     = lo_sum[3];
  assign hi_sum = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
  assign sum    = {hi_sum[0], lo_sum[2:0]};
  assign cout   = hi_sum[1];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide two's-complement add/subtract computed one nibble per clock, LSB first,
// through a single shared 4-bit slice. Optional macro: ADDSUB_ZERO_FLAG_EN.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nibble_serial_addsub_ctrl_if.slave   bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IW    = idx_width(NIBBLES);
  localparam int SLOTS = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t              state_reg;
  state_t              state_next;
  logic [IW-1:0]       idx_reg;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        result_reg;
  logic                carry_reg;
  logic                rsp_carry_reg;
  logic                rsp_ovf_reg;

  logic                req_fire;
  logic                last_nibble;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                slice_c3;

  // Nibble views padded to a power of two so any index value is in range.
  logic [NIBBLE_W-1:0] a_nib [SLOTS];
  logic [NIBBLE_W-1:0] b_nib [SLOTS];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_nib
    if (gi < NIBBLES) begin : g_live
      assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
    end else begin : g_pad
      assign a_nib[gi] = '0;
      assign b_nib[gi] = '0;
    end
  end

  assign slice_a = a_nib[idx_reg];
  assign slice_b = b_nib[idx_reg];

  nibble_add_cin u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  assign req_fire    = (state_reg == IDLE) && bus.req_valid;
  assign last_nibble = (state_reg == RUN) && (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in
  // on the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      result_reg    <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_ovf_reg   <= 1'b0;
    end else if (req_fire) begin
      a_reg     <= bus.req_a;
      b_reg     <= bus.req_b ^ {W{bus.req_sub}};
      carry_reg <= bus.req_sub;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      carry_reg <= slice_cout;
      idx_reg   <= last_nibble ? '0 : idx_reg + 1'b1;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_reg == IW'(i)) begin
          result_reg[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
        end
      end
      if (last_nibble) begin
        rsp_carry_reg <= slice_cout;
        rsp_ovf_reg   <= slice_c3 ^ slice_cout;
      end
    end
  end

  assign bus.rsp_result = result_reg;
  assign bus.rsp_carry  = rsp_carry_reg;
  assign bus.rsp_ovf    = rsp_ovf_reg;

`ifdef ADDSUB_ZERO_FLAG_EN
  logic zero_reg;

  // Running AND of per-nibble zero; restarts on the first nibble of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      zero_reg <= ((idx_reg == '0) ? 1'b1 : zero_reg) & (slice_sum == '0);
    end
  end

  assign bus.rsp_zero = zero_reg;
`endif

endmodule

// File: doc/nibble_serial_addsub_ctrl.md
Name: nibble_serial_addsub_ctrl

Overview:
Sequencer that performs wide (4*NIBBLES-bit) two's-complement add/subtract by time-sharing one 4-bit add-with-carry slice, one nibble per clock, LSB nibble first. The inter-nibble carry is held in a register between cycles. Operands arrive on a valid/ready request channel; results leave on a valid/ready response channel. Sits between the register/operand logic and the writeback path wherever area matters more than latency.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation (operand width W = 4*NIBBLES); legal range 2..16

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  operation request valid
req_ready  output  1  block can accept a request (high only in IDLE)
req_a  input  W  operand A
req_b  input  W  operand B
req_sub  input  1  0 = A+B, 1 = A-B
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accepts result
rsp_result  output  W  sum/difference, modulo 2^W
rsp_carry  output  1  carry out of MSB (subtract: 1 = no borrow, A>=B unsigned)
rsp_ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1 after reset; rsp_valid=0; rsp_result, rsp_carry, rsp_ovf = 0; nibble index = 0; carry register = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready at the clock edge: latch A, B XOR {W{req_sub}}, and carry register <= req_sub; set index 0; go to RUN. Request inputs are ignored after this edge.
- RUN: req_ready=0. On each edge: slice computes latched A nibble[idx] + B' nibble[idx] + carry; the sum is written to result nibble[idx]; carry <= slice cout; idx++. On the edge where idx = NIBBLES-1, capture rsp_carry = slice cout and rsp_ovf = slice bit-3 carry-in XOR cout; go to DONE.
- Latency: rsp_valid rises exactly NIBBLES cycles after the request handshake edge.
- DONE: rsp_valid=1. rsp_result, rsp_carry and rsp_ovf are held stable while rsp_ready=0 (indefinite backpressure). On rsp_valid&&rsp_ready: go to IDLE; rsp_valid=0 next cycle. Minimum issue interval is NIBBLES+1 cycles, because there is no request/response overlap.
- req_valid asserted in RUN or DONE is not accepted. The requester must hold the request until req_ready.
- rsp_result, rsp_carry and rsp_ovf are don't-care when rsp_valid=0, but do not toggle in IDLE. They are cleared only by reset.
- Partial result nibbles are not visible as valid before DONE.
- rst_n asserted in any state, including mid-RUN: immediate return to reset values; the in-flight operation is discarded with no response.
- Arithmetic: all sums are modulo 2^W. A-B is formed as A + ~B + 1.

Optional Feature:
ADDSUB_ZERO_FLAG_EN
- Defined: adds output rsp_zero (1 bit). It is set in DONE when rsp_result == 0 and tracked incrementally (AND of per-nibble zero) during RUN. It resets to 0 and is held with the result under backpressure.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package: FSM state enum (IDLE/RUN/DONE), NIBBLE_W = 4 constant, and a function for index width clog2(NIBBLES).
- One sub-module: nibble_add_cin, a combinational 4-bit adder with cin. Outputs: 4-bit sum, cout, and carry into bit 3 (for overflow). Instantiated once and muxed by the index.

Test Plan:
- NIBBLES=4, A=0x1234, B=0x0FED, sub=0 -> rsp_result=0x2221, carry=0, ovf=0; rsp_valid exactly 4 cycles after handshake.
- A=0x7FFF, B=0x0001, sub=0 -> 0x8000, carry=0, ovf=1. Also A=0xFFFF, B=0x0001, sub=0 -> 0x0000, carry=1, ovf=0 (rsp_zero=1 when ADDSUB_ZERO_FLAG_EN).
- A=0x0003, B=0x0005, sub=1 -> 0xFFFE, carry=0 (borrow), ovf=0. A=0x8000, B=0x0001, sub=1 -> 0x7FFF, carry=1, ovf=1.
- Backpressure: hold rsp_ready=0 for 6 cycles in DONE -> outputs stable, req_ready=0, a new req_valid is not accepted. Release -> rsp_valid drops next cycle and req_ready=1.
- Back-to-back requests with req_valid held high -> second handshake occurs on the cycle after the first response handshake; operands are sampled only at handshake (change req_a mid-RUN, result unaffected).
- Assert rst_n=0 asynchronously at RUN idx=2 -> outputs immediately reset values, state IDLE, no rsp_valid. Next request computes correctly; carry register is not polluted by the aborted run.
